fetch_ctrl: RTL and testbench

Sequences instruction fetch between the IF-stage pc register and a variable-latency instruction memory with a req/gnt/rvalid handshake. Only one request is outstanding at a time. The block presents a held instruction and an instr_valid flag to IF, and raises fetch_stall into the pipeline stall path (ORed with PL_stall at the pc write enable). On PL_flush it discards in-flight responses, so a wrong-path word never reaches IF. It also keeps a saturating fetch-stall performance counter.

---
 rtl/fetch_ctrl_pkg.sv | 10 +
 rtl/fetch_ctrl_sat_counter.sv | 19 +
 rtl/fetch_ctrl.sv | 96 +++++++++
 tb/tb_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch FSM encoding and NOP instruction
package fetch_ctrl_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;
endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + WIDTH'(1);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer with flush discard and stall counter
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          CNT_W = 32,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_i,
    input  logic             PL_stall,
    input  logic             PL_flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      instr_o,
    output logic             instr_valid,
    output logic             fetch_stall,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);
    state_t      state, state_n;
    logic        drop, drop_n;
    logic [31:0] addr_n;
    logic [31:0] instr_q, instr_n;

    assign mem_req     = state == REQ;
    assign instr_valid = state == VALID;
    assign fetch_stall = state != VALID;
    assign instr_o     = instr_valid ? instr_q : NOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            drop     <= 1'b0;
            mem_addr <= '0;
            instr_q  <= NOP;
        end else begin
            state    <= state_n;
            drop     <= drop_n;
            mem_addr <= addr_n;
            instr_q  <= instr_n;
        end
    end

    // A flushed transfer is never withdrawn; drop marks its response for discard.
    always_comb begin
        state_n = state;
        drop_n  = drop;
        addr_n  = mem_addr;
        instr_n = instr_q;
        case (state)
            IDLE: begin
                if (!PL_flush) begin
                    addr_n  = pc_i;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (PL_flush)
                    drop_n = 1'b1;
                if (mem_gnt)
                    state_n = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (drop || PL_flush) begin
                        drop_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        instr_n = mem_rdata;
                        state_n = VALID;
                    end
                end else if (PL_flush) begin
                    drop_n = 1'b1;
                end
            end
            VALID: begin
                if (PL_flush || !PL_stall) begin
                    instr_n = NOP;
                    state_n = IDLE;
                end
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (fetch_stall),
        .cnt (stall_cnt)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized run against a transaction-level fetch model
module tb_fetch_ctrl;
    localparam int          CW  = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_i;
    logic          PL_stall, PL_flush;
    logic          mem_req, mem_gnt, mem_rvalid;
    logic [31:0]   mem_addr, mem_rdata, instr_o;
    logic          instr_valid, fetch_stall, cnt_clr;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .PL_stall    (PL_stall),
        .PL_flush    (PL_flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_o     (instr_o),
        .instr_valid (instr_valid),
        .fetch_stall (fetch_stall),
        .cnt_clr     (cnt_clr),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h2468ACE1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; PL_stall = 1'b0; PL_flush = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; cnt_clr = 1'b0; pc_i = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        pc_i = 32'h80;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        n_cmp++; if (stall_cnt === '0) begin n_err++; $display("FAIL rst_precnt: stall_cnt=%0d required nonzero", stall_cnt); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr_o !== NOP) begin n_err++; $display("FAIL rst_instr: got %h want %h", instr_o, NOP); end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b want 1", fetch_stall); end
        n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        do_reset();
        pc_i = 32'h0;
        n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL zw_idle: req=%b valid=%b want 0 0", mem_req, instr_valid); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_err++; $display("FAIL zw_req: req=%b addr=%h want 1 0", mem_req, mem_addr); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL zw_wait: req=%b valid=%b want 0 0", mem_req, instr_valid); end
        tick();
        mem_rvalid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1 || instr_o !== 32'h00500093 || fetch_stall !== 1'b0) begin
            n_err++; $display("FAIL zw_valid: valid=%b instr=%h stall=%b want 1 00500093 0", instr_valid, instr_o, fetch_stall);
        end
        tick();
        pc_i = 32'h4;
        n_cmp++; if (instr_valid !== 1'b0 || instr_o !== NOP) begin n_err++; $display("FAIL zw_consumed: valid=%b instr=%h want 0 %h", instr_valid, instr_o, NOP); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_err++; $display("FAIL zw_next: req=%b addr=%h want 1 4", mem_req, mem_addr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        pc_i = 32'h8;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_rvalid = 1'b0; PL_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (instr_valid !== 1'b1 || instr_o !== 32'h00500093 || fetch_stall !== 1'b0 || mem_req !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d: valid=%b instr=%h stall=%b req=%b want 1 00500093 0 0", i, instr_valid, instr_o, fetch_stall, mem_req);
            end
        end
        PL_stall = 1'b0;
        tick();
        n_cmp++; if (instr_valid !== 1'b0 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL bp_release: valid=%b stall=%b want 0 1", instr_valid, fetch_stall); end
    endtask

    task automatic test_flush_wait();
        do_reset();
        pc_i = 32'h40;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; PL_flush = 1'b1;
        tick();
        PL_flush = 1'b0; pc_i = 32'h100;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL fw_wait1: valid=%b want 0", instr_valid); end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || instr_o !== NOP) begin n_err++; $display("FAIL fw_discard: valid=%b instr=%h want 0 %h", instr_valid, instr_o, NOP); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            n_err++; $display("FAIL fw_next: req=%b addr=%h valid=%b want 1 100 0", mem_req, mem_addr, instr_valid);
        end
    endtask

    task automatic test_flush_req();
        do_reset();
        pc_i = 32'h40;
        tick();
        PL_flush = 1'b1;
        tick();
        PL_flush = 1'b0; pc_i = 32'h200;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_err++; $display("FAIL fr_hold%0d: req=%b addr=%h want 1 40", i, mem_req, mem_addr); end
            tick();
        end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_err++; $display("FAIL fr_hold2: req=%b addr=%h want 1 40", mem_req, mem_addr); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBADC0DE5;
        tick();
        mem_rvalid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL fr_discard: valid=%b want 0", instr_valid); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_err++; $display("FAIL fr_next: req=%b addr=%h want 1 200", mem_req, mem_addr); end
    endtask

    task automatic test_counter();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_cmp++; if (stall_cnt !== CW'((k > 15) ? 15 : k)) begin n_err++; $display("FAIL cnt_k%0d: got %0d want %0d", k, stall_cnt, (k > 15) ? 15 : k); end
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL cnt_clr: got %0d want 0", stall_cnt); end
        tick();
        n_cmp++; if (stall_cnt !== CW'(1)) begin n_err++; $display("FAIL cnt_resume: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_random();
        logic [31:0]   pc, pc_nxt, req_addr;
        logic [CW-1:0] cnt_m;
        logic          outstanding, taint, pend, prev_req, chk_resp, resp_good;
        int            dly;
        do_reset();
        pc = 32'h1000; pc_nxt = pc; pc_i = pc; req_addr = '0; cnt_m = '0;
        outstanding = 0; taint = 0; pend = 0; prev_req = 0; chk_resp = 0; resp_good = 0; dly = 0;
        for (int c = 0; c < 3000; c++) begin
            n_cmp++; if (stall_cnt !== cnt_m) begin n_err++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, stall_cnt, cnt_m); end
            n_cmp++; if (fetch_stall !== !instr_valid) begin n_err++; $display("FAIL rnd_stall@%0d: stall=%b valid=%b", c, fetch_stall, instr_valid); end
            if (!instr_valid) begin
                n_cmp++; if (instr_o !== NOP) begin n_err++; $display("FAIL rnd_nop@%0d: got %h want %h", c, instr_o, NOP); end
            end
            if (chk_resp) begin
                n_cmp++; if (instr_valid !== resp_good) begin n_err++; $display("FAIL rnd_deliver@%0d: valid=%b want %b", c, instr_valid, resp_good); end
                if (resp_good && instr_valid) begin
                    n_cmp++; if (instr_o !== mem_word(req_addr)) begin n_err++; $display("FAIL rnd_data@%0d: got %h want %h", c, instr_o, mem_word(req_addr)); end
                end
            end
            chk_resp = 0;
            if (mem_req && !prev_req) begin
                n_cmp++; if (mem_addr !== pc) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", c, mem_addr, pc); end
                req_addr = pc; outstanding = 1; taint = 0;
            end
            prev_req = mem_req;
            pc = pc_nxt; pc_i = pc;
            PL_flush = ($urandom_range(0, 7) == 0);
            PL_stall = $urandom_range(0, 1) == 1;
            cnt_clr  = ($urandom_range(0, 49) == 0);
            cnt_m = cnt_clr ? '0 : (fetch_stall && cnt_m != '1) ? cnt_m + CW'(1) : cnt_m;
            pc_nxt = PL_flush ? {20'h0, 10'($urandom_range(0, 1023)), 2'b00} : (instr_valid && !PL_stall) ? pc + 32'h4 : pc;
            if (outstanding && PL_flush) taint = 1;
            mem_rdata = $urandom;
            mem_rvalid = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = mem_word(req_addr);
                    pend = 0; outstanding = 0; chk_resp = 1; resp_good = !taint;
                end else begin
                    dly--;
                end
            end
            mem_gnt = mem_req && ($urandom_range(0, 1) == 1);
            if (mem_gnt) begin
                pend = 1; dly = $urandom_range(0, 2);
            end
            tick();
        end
        PL_flush = 1'b0; PL_stall = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_flush_wait();
        test_flush_req();
        test_counter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
